// File: rtl/aes_pkg.sv
// AES-128 shared types, round constants and word helpers for the key paths.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package aes_pkg;

  typedef logic [31:0] word_t;
  typedef word_t [0:3] key_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_SUB    = 2'd2,
    ST_UPDATE = 2'd3
  } ks_state_t;

  // Round constants, indexed by round number 1..10; other slots are zero so an
  // out-of-range index contributes nothing to the XOR.
  localparam logic [7:0] RCON [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/sbox_sync.sv
// AES forward S-box ROM, 256x8, one lookup per cycle.
// Latency: 1 cycle (registered output, no reset).
// Backpressure: none; a new address is accepted every cycle.
module sbox_sync (
  input  logic       clk,
  input  logic [7:0] i_addr,
  output logic [7:0] o_data
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [7:0] r_data;

  // Registered ROM read so the lookup maps onto a synchronous memory.
  always_ff @(posedge clk) begin
    r_data <= SBOX[i_addr];
  end

  assign o_data = r_data;

endmodule

// File: rtl/inv_key_schedule.sv
// Reverse AES-128 key schedule: loads the round-NR key, emits round keys NR down to 0.
// Latency: first key 1 cycle after accepted start; then at best one key every 3 cycles.
// Backpressure: key_valid/round_key/key_round held stable until key_ready; no advance before accept.
module inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] last_key,
  output logic [127:0] round_key,
  output logic [3:0]   key_round,
  output logic         key_valid,
  input  logic         key_ready,
  output logic         busy,
  output logic         done
);

  ks_state_t r_state;
  key_t      r_key;
  logic [3:0] r_round;
  logic      r_valid;
  logic      r_busy;
  logic      r_done;

  word_t     w_t;
  word_t     w_sub;
  key_t      w_prev;

  // SubWord input is taken straight from the held key; it is stable through SUB and
  // UPDATE, so the registered S-box result is valid by the UPDATE cycle.
  assign w_t = rot_word(r_key[3] ^ r_key[2]);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox_sync u_sbox (
      .clk    (clk),
      .i_addr (w_t[8*g +: 8]),
      .o_data (w_sub[8*g +: 8])
    );
  end

  // Undo one forward expansion step: later words recover earlier ones by XOR alone,
  // word 0 additionally needs SubWord and the round constant of the round being undone.
  always_comb begin
    w_prev[3] = r_key[3] ^ r_key[2];
    w_prev[2] = r_key[2] ^ r_key[1];
    w_prev[1] = r_key[1] ^ r_key[0];
    w_prev[0] = r_key[0] ^ w_sub ^ {RCON[r_round], 24'h0};
  end

  // Schedule controller: load, emit with backpressure, wait for S-box, step back a round.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_key   <= '0;
      r_round <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_key   <= last_key;
            r_round <= 4'(NR);
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (key_ready) begin
            r_valid <= 1'b0;
            if (r_round == 4'd0) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_SUB;
            end
          end
        end
        ST_SUB: begin
          r_state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          r_key   <= w_prev;
          r_round <= r_round - 4'd1;
          r_valid <= 1'b1;
          r_state <= ST_EMIT;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign round_key = r_key;
  assign key_round = r_round;
  assign key_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Scoreboard bench for the reverse AES-128 key schedule.
// Latency: checks first key 1 cycle after start and 3-cycle key spacing.
// Backpressure: exercises key_ready stalls and random ready patterns.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [127:0] last_key;
  logic [127:0] round_key;
  logic [3:0]   key_round;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  inv_key_schedule dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .last_key  (last_key),
    .round_key (round_key),
    .key_round (key_round),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
  } exp_t;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int done_cnt = 0;
  int acc_cnt = 0;
  int base_done = 0;
  int base_acc = 0;
  logic [127:0] r0_seen = '0;
  logic prev_busy = 1'b0;

  logic [7:0] sb [256];
  logic [7:0] rc [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Published AES-128 example schedule, rounds 0..10.
  logic [127:0] fips [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Reference S-box from GF(2^8) inversion plus the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
              {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] next_key(input logic [127:0] k, input int i);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t = {w3[23:0], w3[31:24]};
    t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc[i], 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] expand_to10(input logic [127:0] k0);
    logic [127:0] k;
    k = k0;
    for (int i = 1; i <= 10; i++) k = next_key(k, i);
    return k;
  endfunction

  task automatic push_fips();
    exp_t e;
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r);
      e.key = fips[r];
      exp_q.push_back(e);
    end
  endtask

  task automatic push_model(input logic [127:0] k0);
    logic [127:0] ks [0:10];
    exp_t e;
    ks[0] = k0;
    for (int i = 1; i <= 10; i++) ks[i] = next_key(ks[i-1], i);
    for (int r = 10; r >= 0; r--) begin
      e.rnd = 4'(r);
      e.key = ks[r];
      exp_q.push_back(e);
    end
  endtask

  task automatic start_run(input logic [127:0] k);
    @(posedge clk); #1;
    base_done = done_cnt;
    base_acc  = acc_cnt;
    last_key  = k;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("first_valid", 128'(key_valid), 128'(1));
    chk("first_round", 128'(key_round), 128'(10));
    chk("first_key", round_key, k);
  endtask

  task automatic wait_done(input string nm, input bit rnd_rdy);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk); #1;
      if (rnd_rdy) key_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_done required=done", nm);
    end
  endtask

  task automatic check_run(input string nm, input logic [127:0] k10);
    repeat (2) @(posedge clk);
    #1;
    key_ready = 1'b1;
    chk({nm, "_done_pulses"}, 128'(done_cnt - base_done), 128'(1));
    chk({nm, "_key_count"}, 128'(acc_cnt - base_acc), 128'(11));
    chk({nm, "_r0_reexpand"}, expand_to10(r0_seen), k10);
    chk({nm, "_idle_valid"}, 128'(key_valid), 128'(0));
    chk({nm, "_idle_busy"}, 128'(busy), 128'(0));
  endtask

  // Monitor: pops the scoreboard on every accepted key and audits done/busy.
  always @(negedge clk) begin
    if (reset_n) begin
      if (key_valid && key_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key actual_round=%0d required=no_key", key_round);
        end else begin
          mon_e = exp_q.pop_front();
          chk("key_round", 128'(key_round), 128'(mon_e.rnd));
          chk("round_key", round_key, mon_e.key);
        end
        if (key_round == 4'd0) r0_seen = round_key;
      end
      if (done) begin
        done_cnt++;
        chk("busy_low_with_done", 128'(busy), 128'(0));
        chk("busy_high_before_done", 128'(prev_busy), 128'(1));
      end
    end
    prev_busy = busy;
  end

  initial begin
    logic [127:0] k0;
    logic [127:0] k10;
    logic [127:0] other;
    int n;
    bit hit;
    bit stay_low;

    reset_n  = 1'b0;
    start    = 1'b0;
    key_ready = 1'b0;
    last_key = '0;
    build_sbox();
    #12;
    chk("rst_valid", 128'(key_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_key", round_key, 128'(0));
    chk("rst_round", 128'(key_round), 128'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Full published schedule with ready held high; key spacing of 3 cycles.
    key_ready = 1'b1;
    push_fips();
    start_run(fips[10]);
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); #1;
      n++;
      if (key_valid && key_round == 4'd9) hit = 1'b1;
    end
    chk("key_interval", 128'(n), 128'(3));
    wait_done("t1", 1'b0);
    check_run("t1", fips[10]);

    // Stall five cycles while round 7 is presented.
    push_fips();
    start_run(fips[10]);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      if (key_valid && key_round == 4'd7) hit = 1'b1;
    end
    key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 128'(key_valid), 128'(1));
      chk("stall_round", 128'(key_round), 128'(7));
      chk("stall_key", round_key, fips[7]);
    end
    @(posedge clk); #1;
    key_ready = 1'b1;
    wait_done("t3", 1'b0);
    check_run("t3", fips[10]);

    // start held high with another key for the whole run, including the final accept.
    k0 = {$urandom, $urandom, $urandom, $urandom};
    other = expand_to10(k0);
    push_fips();
    start_run(fips[10]);
    for (int i = 0; i < 200; i++) begin
      start = 1'b1;
      last_key = other;
      @(posedge clk); #1;
      if (!busy) break;
    end
    start = 1'b0;
    check_run("t4", fips[10]);
    push_model(k0);
    start_run(other);
    wait_done("t4b", 1'b0);
    check_run("t4b", other);

    // Reset during SUB of round 4 aborts; nothing resumes until a fresh start.
    push_fips();
    start_run(fips[10]);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (key_valid && key_round == 4'd4) hit = 1'b1;
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 128'(key_valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    chk("arst_key", round_key, 128'(0));
    chk("arst_round", 128'(key_round), 128'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    stay_low = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (key_valid || busy) stay_low = 1'b0;
    end
    chk("post_reset_quiet", 128'(stay_low), 128'(1));
    push_fips();
    start_run(fips[10]);
    wait_done("t5", 1'b0);
    check_run("t5", fips[10]);

    // Random keys against the forward reference, random ready pattern.
    for (int j = 0; j < 4; j++) begin
      k0 = {$urandom, $urandom, $urandom, $urandom};
      k10 = expand_to10(k0);
      push_model(k0);
      start_run(k10);
      wait_done("t6", 1'b1);
      check_run("t6", k10);
    end

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
Reverse AES-128 key schedule for the decryption datapath. Loads the final (round 10) round key and emits round keys 10, 9, … 0 in descending order, one per valid/ready handshake. This lets the inverse cipher consume keys in decryption order without storing all 11 forward-expanded keys. It sits between the key-load logic and the inverse-cipher round controller.

Parameters:
NR, 10, number of AES rounds; fixed for AES-128, and the first emitted round index.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a schedule; sampled only in IDLE
last_key  in  128  round-10 key; word0 = bits[127:96], word3 = bits[31:0]; sampled on accepted start
round_key  out  128  current round key, same word ordering as last_key
key_round  out  4  round index of round_key (10 down to 0)
key_valid  out  1  round_key/key_round are valid; held until accepted
key_ready  in  1  consumer accepts when key_valid && key_ready
busy  out  1  high from accepted start until final accept
done  out  1  one-cycle pulse in the cycle after round 0 is accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE; round_key=0, key_round=0, key_valid=0, busy=0, done=0; internal key and round registers cleared.
- Reset asserted mid-schedule aborts immediately. There is no partial output after release, and a new start is required.
- States: IDLE, EMIT, SUB, UPDATE.
- IDLE: when start=1, load key_reg=last_key and round=NR, set busy=1, go to EMIT. start is ignored in every other state.
- EMIT: key_valid=1, round_key=key_reg, key_round=round. Outputs stay stable while key_ready=0.
  - On accept with round==0: key_valid=0, busy=0, done=1 for the next cycle, go to IDLE.
  - On accept with round>0: key_valid=0, go to SUB.
- SUB: present t = RotWord(w3 ^ w2) to four synchronous S-box lookups; the registered result is available next cycle. Go to UPDATE.
- UPDATE: compute the previous round key from the current words w0..w3 (XOR only, no carries):
  - p3 = w3 ^ w2
  - p2 = w2 ^ w1
  - p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(t) ^ {Rcon[round], 24'h0}
  - Then key_reg = {p0, p1, p2, p3}, round = round-1, go to EMIT.
- Rcon indexed by the round being undone: 1..10 = 01,02,04,08,10,20,40,80,1b,36.
- Throughput: minimum 3 cycles per key (EMIT accept, SUB, UPDATE). Latency from accepted start to first key_valid is 1 cycle.
- key_ready high outside EMIT has no effect.
- start and the final accept may coincide; start is not sampled until the cycle the FSM is back in IDLE.
- key_round never wraps below 0, and no state is reachable beyond round 0.
- Unused/illegal state encodings recover to IDLE.

Decomposition:
- Shared package aes_pkg:
  - typedef word_t (32-bit) and key_t ([0:3] of word_t)
  - the Rcon constant table (indexed 1..10)
  - the enum for IDLE/EMIT/SUB/UPDATE
  - the function rot_word
- Sub-module sbox_sync: 256x8 S-box ROM with registered output and one-cycle latency, clk-only. It is instantiated four times for the word lookup and is reused by the forward key path.

Test Plan:
1. Reset, then start with last_key=d014f9a8c9ee2589e13f0cc8b6630ca6 and key_ready held 1 -> first key_valid 1 cycle after start with key_round=10 and that key; next key (round 9) = ac7766f319fadc2128d12941575c006e after 3 cycles.
2. Same run continued -> key_round=1 yields a0fafe1788542cb123a339392a6c7605; key_round=0 yields 2b7e151628aed2a6abf7158809cf4f3c; done pulses exactly once; busy falls the same cycle; 11 keys total.
3. key_ready held 0 for 5 cycles while round 7 is valid -> round_key/key_round stay constant and no round advance; after release the sequence continues with correct round 6 key.
4. Assert start repeatedly while busy with a different last_key -> sequence unaffected; new start after done loads the new key and restarts at round 10.
5. Drop reset_n during SUB of round 4 -> all outputs 0 asynchronously; after release key_valid stays 0 until a fresh start, which then produces the full correct sequence.
6. Random last_key values checked against a reference forward expansion run backwards -> all 11 keys match, and the round-0 key re-expands to the loaded last_key.
